// File: rtl/scan_sel_gen.sv
// Scan controller: walks a 3-bit select over eight display positions and presents the shadowed nibble.
// Optional inter-position blanking is compiled in when SCAN_BLANK_EN is defined.
module scan_sel_gen #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] digits,
  input  logic [7:0]  mask,
  output logic [2:0]  sel,
  output logic [3:0]  nibble,
  output logic        blank,
  output logic        frame_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
`ifdef SCAN_BLANK_EN
  localparam logic [1:0] ST_BLANK = 2'd2;
  localparam int BCNT_W = $clog2(BLANK_CYC + 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLANK_CYC - 1);
  logic [BCNT_W-1:0] r_bcnt;
`endif

  // Out-of-range parameters leave an empty marker scope in the elaborated hierarchy.
  if (CLK_DIV < 2 || BLANK_CYC < 1) begin : g_bad_params
  end

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic [31:0]      r_shadow_digits;
  logic [7:0]       r_shadow_mask;
  logic [2:0]       r_sel;
  logic [3:0]       r_nibble;
  logic             r_blank;
  logic             r_frame_done;

  logic [3:0] w_shadow_nib [0:7];
  logic [2:0] w_sel_inc;
  logic       w_wrap;
  logic [3:0] w_adv_nibble;
  logic       w_adv_blank;
  logic       w_advance;

  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    assign w_shadow_nib[gi] = r_shadow_digits[4*gi +: 4];
  end

  assign w_sel_inc = r_sel + 3'd1;
  assign w_wrap    = (r_sel == 3'd7);

  // On wrap the fresh inputs are shown directly, since the shadows reload on that same edge.
  assign w_adv_nibble = w_wrap ? digits[3:0] : w_shadow_nib[w_sel_inc];
  assign w_adv_blank  = w_wrap ? ~mask[0]    : ~r_shadow_mask[w_sel_inc];

`ifdef SCAN_BLANK_EN
  assign w_advance = en && (r_state == ST_BLANK) && (r_bcnt == BCNT_LAST);
`else
  assign w_advance = en && (r_state == ST_SHOW) && (r_div == DIV_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_div           <= '0;
      r_shadow_digits <= '0;
      r_shadow_mask   <= '0;
      r_sel           <= 3'd0;
      r_nibble        <= 4'd0;
      r_blank         <= 1'b1;
      r_frame_done    <= 1'b0;
`ifdef SCAN_BLANK_EN
      r_bcnt          <= '0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      if (!en && r_state != ST_IDLE) begin
        r_state  <= ST_IDLE;
        r_div    <= '0;
        r_sel    <= 3'd0;
        r_nibble <= 4'd0;
        r_blank  <= 1'b1;
`ifdef SCAN_BLANK_EN
        r_bcnt   <= '0;
`endif
      end else if (w_advance) begin
        r_state  <= ST_SHOW;
        r_div    <= '0;
        r_sel    <= w_sel_inc;
        r_nibble <= w_adv_nibble;
        r_blank  <= w_adv_blank;
        if (w_wrap) begin
          r_frame_done    <= 1'b1;
          r_shadow_digits <= digits;
          r_shadow_mask   <= mask;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (en) begin
              r_state         <= ST_SHOW;
              r_div           <= '0;
              r_sel           <= 3'd0;
              r_shadow_digits <= digits;
              r_shadow_mask   <= mask;
              r_nibble        <= digits[3:0];
              r_blank         <= ~mask[0];
            end
          end
          ST_SHOW: begin
            if (r_div != DIV_LAST) begin
              r_div <= r_div + DIV_W'(1);
            end
`ifdef SCAN_BLANK_EN
            else begin
              r_state <= ST_BLANK;
              r_blank <= 1'b1;
              r_bcnt  <= '0;
            end
`endif
          end
`ifdef SCAN_BLANK_EN
          ST_BLANK: begin
            r_bcnt <= r_bcnt + BCNT_W'(1);
          end
`endif
          default: begin
            r_state  <= ST_IDLE;
            r_sel    <= 3'd0;
            r_nibble <= 4'd0;
            r_blank  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign sel        = r_sel;
  assign nibble     = r_nibble;
  assign blank      = r_blank;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed bench for scan_sel_gen with CLK_DIV=4, BLANK_CYC=2; expectations follow SCAN_BLANK_EN.
module tb_scan_sel_gen;

  localparam int CLK_DIV   = 4;
  localparam int BLANK_CYC = 2;
`ifdef SCAN_BLANK_EN
  localparam int GAP = BLANK_CYC;
`else
  localparam int GAP = 0;
`endif
  localparam int POS   = CLK_DIV + GAP;
  localparam int FRAME = 8 * POS;
  localparam logic [8:0] IDLE_OUT = 9'b000_0000_1_0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] digits = 32'h0;
  logic [7:0]  mask = 8'h0;
  logic [2:0]  sel;
  logic [3:0]  nibble;
  logic        blank;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  scan_sel_gen #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .mask(mask),
    .sel(sel), .nibble(nibble), .blank(blank), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected {sel,nibble,blank,frame_done} at cycle c after the enabling edge.
  function automatic logic [8:0] exp_out(int c, logic [7:0] m, logic [31:0] d0, logic [31:0] d1);
    int pos, ph;
    logic [31:0] d;
    logic [3:0] nib;
    logic bl, fd;
    pos = (c / POS) % 8;
    ph  = c % POS;
    d   = (c >= FRAME) ? d1 : d0;
    nib = d[pos*4 +: 4];
    bl  = (ph >= CLK_DIV) || !m[pos];
    fd  = (c > 0) && (c % FRAME == 0);
    return {pos[2:0], nib, bl, fd};
  endfunction

  task automatic test_reset;
    logic [8:0] obs;
    #12;
    obs = {sel, nibble, blank, frame_done};
    tests++;
    if (obs !== IDLE_OUT) begin
      fails++;
      $display("FAIL reset_held: got %h, expected %h", obs, IDLE_OUT);
    end
    #3 rst_n = 1'b1;
    tick;
    tick;
    obs = {sel, nibble, blank, frame_done};
    tests++;
    if (obs !== IDLE_OUT) begin
      fails++;
      $display("FAIL reset_idle_en0: got %h, expected %h", obs, IDLE_OUT);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_walk;
    logic [8:0] obs, exp;
    digits = 32'h7654_3210;
    mask   = 8'hFF;
    en     = 1'b1;
    for (int c = 0; c <= 2 * FRAME; c++) begin
      tick;
      obs = {sel, nibble, blank, frame_done};
      exp = exp_out(c, 8'hFF, 32'h7654_3210, 32'h7654_3210);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL walk cycle %0d: got {sel,nib,blank,fd}=%h, expected %h", c, obs, exp);
      end
    end
    en = 1'b0;
    tick;
    obs = {sel, nibble, blank, frame_done};
    tests++;
    if (obs !== IDLE_OUT) begin
      fails++;
      $display("FAIL walk_stop: got %h, expected %h", obs, IDLE_OUT);
    end
    $display("[TB] test_walk done");
  endtask

  task automatic test_mask;
    logic [8:0] obs, exp;
    digits = 32'h7654_3210;
    mask   = 8'b1010_1010;
    en     = 1'b1;
    for (int c = 0; c <= FRAME; c++) begin
      tick;
      obs = {sel, nibble, blank, frame_done};
      exp = exp_out(c, 8'b1010_1010, 32'h7654_3210, 32'h7654_3210);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL mask cycle %0d: got {sel,nib,blank,fd}=%h, expected %h", c, obs, exp);
      end
    end
    en = 1'b0;
    tick;
    $display("[TB] test_mask done");
  endtask

  task automatic test_shadow;
    logic [8:0] obs, exp;
    digits = 32'h7654_3210;
    mask   = 8'hFF;
    en     = 1'b1;
    for (int c = 0; c < FRAME + POS; c++) begin
      tick;
      obs = {sel, nibble, blank, frame_done};
      exp = exp_out(c, 8'hFF, 32'h7654_3210, 32'hFFFF_FFFF);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL shadow cycle %0d: got {sel,nib,blank,fd}=%h, expected %h", c, obs, exp);
      end
      if (c == 3 * POS + 1) digits = 32'hFFFF_FFFF;
    end
    en = 1'b0;
    tick;
    $display("[TB] test_shadow done");
  endtask

  task automatic test_drop_en;
    logic [8:0] obs, exp;
    int target;
    target = 5 * POS + ((GAP > 0) ? CLK_DIV : 2);
    digits = 32'h89AB_CDEF;
    mask   = 8'hFF;
    en     = 1'b1;
    for (int c = 0; c <= target; c++) begin
      tick;
      obs = {sel, nibble, blank, frame_done};
      exp = exp_out(c, 8'hFF, 32'h89AB_CDEF, 32'h89AB_CDEF);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL drop_pre cycle %0d: got %h, expected %h", c, obs, exp);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      obs = {sel, nibble, blank, frame_done};
      tests++;
      if (obs !== IDLE_OUT) begin
        fails++;
        $display("FAIL drop_idle step %0d: got %h, expected %h", i, obs, IDLE_OUT);
      end
    end
    en = 1'b1;
    for (int c = 0; c < 2 * POS; c++) begin
      tick;
      obs = {sel, nibble, blank, frame_done};
      exp = exp_out(c, 8'hFF, 32'h89AB_CDEF, 32'h89AB_CDEF);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL drop_restart cycle %0d: got %h, expected %h", c, obs, exp);
      end
    end
    en = 1'b0;
    tick;
    $display("[TB] test_drop_en done");
  endtask

  task automatic test_async_reset;
    logic [8:0] obs, exp;
    digits = 32'h89AB_CDEF;
    mask   = 8'hFE;
    en     = 1'b1;
    for (int c = 0; c <= 2 * POS + 1; c++) begin
      tick;
      obs = {sel, nibble, blank, frame_done};
      exp = exp_out(c, 8'hFE, 32'h89AB_CDEF, 32'h89AB_CDEF);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL areset_pre cycle %0d: got %h, expected %h", c, obs, exp);
      end
    end
    #3 rst_n = 1'b0;
    #1;
    obs = {sel, nibble, blank, frame_done};
    tests++;
    if (obs !== IDLE_OUT) begin
      fails++;
      $display("FAIL areset_immediate: got %h, expected %h", obs, IDLE_OUT);
    end
    #2 rst_n = 1'b1;
    tick;
    obs = {sel, nibble, blank, frame_done};
    exp = exp_out(0, 8'hFE, 32'h89AB_CDEF, 32'h89AB_CDEF);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL areset_reentry: got %h, expected %h", obs, exp);
    end
    en = 1'b0;
    tick;
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    test_reset;
    test_walk;
    test_mask;
    test_shadow;
    test_drop_en;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
